// File: rtl/chamber_pressure_plant.sv
// chamber_pressure_plant
// Responder for the airlock pressurize/evacuate command interface. It accepts
// single-cycle requests, times the pump cycle in whole seconds and reports the
// chamber state. Pump activity is aborted to FAULT if either port opens.
//
// Ports:
//   clock, reset                  system clock, asynchronous active-high reset
//   pressurizeReq, evacuateReq    one-cycle request pulses (synchronised)
//   innerPortOpen, outerPortOpen  port open levels (synchronised)
//   pressurized, evacuated        chamber status flags
//   busy, fault                   pump cycle running / cycle aborted
//   done                          one-cycle pulse on cycle completion
//   seconds                       elapsed whole seconds of the current cycle
//   reject                        (only with PRESSURE_REJECT_EN) one-cycle
//                                 pulse for every ignored request
//
// Optional feature macro: PRESSURE_REJECT_EN
module chamber_pressure_plant #(
    parameter int unsigned TICKS_PER_SEC = 64,
    parameter int unsigned PRESS_SEC     = 7,
    parameter int unsigned EVAC_SEC      = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pressurizeReq,
    input  logic       evacuateReq,
    input  logic       innerPortOpen,
    input  logic       outerPortOpen,
    output logic       pressurized,
    output logic       evacuated,
    output logic       busy,
    output logic       fault,
    output logic       done,
`ifdef PRESSURE_REJECT_EN
    output logic       reject,
`endif
    output logic [3:0] seconds
);

    localparam int unsigned TICK_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SEC_W    = 4;

    typedef enum logic [2:0] {
        EVACUATED    = 3'd0,
        PRESSURIZING = 3'd1,
        PRESSURIZED  = 3'd2,
        EVACUATING   = 3'd3,
        FAULT        = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [SEC_W-1:0]   seconds_q, seconds_d;
    logic               pressurized_q, pressurized_d;
    logic               evacuated_q, evacuated_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic               done_q, done_d;

    logic               ports_closed_c;
    logic               press_only_c;
    logic               evac_only_c;
    logic               accepted_c;
    logic [SEC_W-1:0]   target_c;

    assign ports_closed_c = !innerPortOpen && !outerPortOpen;
    assign press_only_c   = pressurizeReq && !evacuateReq;
    assign evac_only_c    = evacuateReq && !pressurizeReq;

    // Next-state, timer and registered-output computation
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        seconds_d  = seconds_q;
        done_d     = 1'b0;
        accepted_c = 1'b0;
        target_c   = (state_q == PRESSURIZING) ? SEC_W'(PRESS_SEC) : SEC_W'(EVAC_SEC);

        case (state_q)
            EVACUATED: begin
                if (press_only_c && ports_closed_c) begin
                    state_d    = PRESSURIZING;
                    tick_d     = '0;
                    seconds_d  = '0;
                    accepted_c = 1'b1;
                end
            end
            PRESSURIZED, FAULT: begin
                if (evac_only_c && ports_closed_c) begin
                    state_d    = EVACUATING;
                    tick_d     = '0;
                    seconds_d  = '0;
                    accepted_c = 1'b1;
                end
            end
            PRESSURIZING, EVACUATING: begin
                // An open port wins over a completion landing in the same cycle
                if (!ports_closed_c) begin
                    state_d = FAULT;
                end else if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
                    tick_d    = '0;
                    seconds_d = seconds_q + SEC_W'(1);
                    if (seconds_d == target_c) begin
                        state_d = (state_q == PRESSURIZING) ? PRESSURIZED : EVACUATED;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        pressurized_d = (state_d == PRESSURIZED);
        evacuated_d   = (state_d == EVACUATED);
        busy_d        = (state_d == PRESSURIZING) || (state_d == EVACUATING);
        fault_d       = (state_d == FAULT);
    end

`ifdef PRESSURE_REJECT_EN
    logic reject_q, reject_d;

    // Every request pulse that did not start a cycle is reported
    always_comb begin
        reject_d = (pressurizeReq || evacuateReq) && !accepted_c;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_d;
        end
    end

    assign reject = reject_q;
`endif

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= EVACUATED;
            tick_q        <= '0;
            seconds_q     <= '0;
            pressurized_q <= 1'b0;
            evacuated_q   <= 1'b1;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            seconds_q     <= seconds_d;
            pressurized_q <= pressurized_d;
            evacuated_q   <= evacuated_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
            done_q        <= done_d;
        end
    end

    assign pressurized = pressurized_q;
    assign evacuated   = evacuated_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign done        = done_q;
    assign seconds     = seconds_q;

endmodule

// File: tb/tb_chamber_pressure_plant.sv
// tb_chamber_pressure_plant
// Directed vector table for the listed scenarios, a hand-written mid-cycle
// reset sequence, then random stimulus against an elapsed-cycle model.
module tb_chamber_pressure_plant;

    localparam int unsigned T  = 4;
    localparam int unsigned PS = 7;
    localparam int unsigned ES = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pressurizeReq = 1'b0;
    logic       evacuateReq = 1'b0;
    logic       innerPortOpen = 1'b0;
    logic       outerPortOpen = 1'b0;
    logic       pressurized, evacuated, busy, fault, done;
    logic [3:0] seconds;
`ifdef PRESSURE_REJECT_EN
    logic       reject;
`endif

    int total = 0;
    int bad   = 0;

    chamber_pressure_plant #(.TICKS_PER_SEC(T), .PRESS_SEC(PS), .EVAC_SEC(ES)) dut (
        .clock(clock), .reset(reset),
        .pressurizeReq(pressurizeReq), .evacuateReq(evacuateReq),
        .innerPortOpen(innerPortOpen), .outerPortOpen(outerPortOpen),
        .pressurized(pressurized), .evacuated(evacuated),
        .busy(busy), .fault(fault), .done(done),
`ifdef PRESSURE_REJECT_EN
        .reject(reject),
`endif
        .seconds(seconds)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, pass the edge, sample 1 time unit later
    task automatic cycle(input bit pr, input bit ev, input bit ip, input bit op);
        pressurizeReq = pr;
        evacuateReq   = ev;
        innerPortOpen = ip;
        outerPortOpen = op;
        @(posedge clock);
        #1;
        pressurizeReq = 1'b0;
        evacuateReq   = 1'b0;
    endtask

    // Reference model: mode plus elapsed cycles of the running pump cycle.
    // 0 vacuum, 1 full pressure, 2 filling, 3 emptying, 4 aborted
    int m_mode, m_elapsed;
    bit m_done, m_rej;

    function automatic void model_reset();
        m_mode = 0; m_elapsed = 0; m_done = 0; m_rej = 0;
    endfunction

    function automatic void model_step(input bit pr, input bit ev, input bit ip, input bit op);
        bit closed = !ip && !op;
        bit running = (m_mode == 2) || (m_mode == 3);
        bit ok;
        int secs;
        m_done = 0;
        m_rej  = 0;
        if (running) begin
            if (pr || ev) m_rej = 1;
            if (!closed) m_mode = 4;
            else begin
                m_elapsed++;
                secs = (m_mode == 2) ? PS : ES;
                if (m_elapsed == secs * T) begin
                    m_mode = (m_mode == 2) ? 1 : 0;
                    m_done = 1;
                end
            end
        end else begin
            ok = (pr != ev) && closed &&
                 ((pr && m_mode == 0) || (ev && (m_mode == 1 || m_mode == 4)));
            if (ok) begin
                m_mode    = pr ? 2 : 3;
                m_elapsed = 0;
            end else if (pr || ev) begin
                m_rej = 1;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".pressurized"}, 32'(pressurized), 32'(m_mode == 1));
        chk({tag, ".evacuated"},   32'(evacuated),   32'(m_mode == 0));
        chk({tag, ".busy"},        32'(busy),        32'(m_mode == 2 || m_mode == 3));
        chk({tag, ".fault"},       32'(fault),       32'(m_mode == 4));
        chk({tag, ".done"},        32'(done),        32'(m_done));
        chk({tag, ".seconds"},     32'(seconds),     32'(m_elapsed / T));
`ifdef PRESSURE_REJECT_EN
        chk({tag, ".reject"},      32'(reject),      32'(m_rej));
`endif
        chk({tag, ".onehot"}, 32'(int'(pressurized) + int'(evacuated) + int'(busy) + int'(fault)), 32'd1);
    endtask

    typedef struct {
        bit pr, ev, ip, op;
        int cyc;
        bit p, e, b, f, d, r;
        int sec;
    } vec_t;

    vec_t vq[$];

    initial begin
        // Directed vectors: request on first cycle only, ports held for all cycles
        //               pr ev ip op cyc  p e b f d r sec
        vq.push_back('{1, 0, 0, 0, 1,  0,0,1,0,0,0, 0});  // start pressurize
        vq.push_back('{0, 0, 0, 0, 27, 0,0,1,0,0,0, 6});
        vq.push_back('{0, 0, 0, 0, 1,  1,0,0,0,1,0, 7});  // done 29 cycles after request
        vq.push_back('{0, 0, 0, 0, 1,  1,0,0,0,0,0, 7});  // seconds held
        vq.push_back('{0, 1, 0, 0, 1,  0,0,1,0,0,0, 0});  // start evacuate
        vq.push_back('{0, 0, 0, 0, 19, 0,0,1,0,0,0, 4});
        vq.push_back('{0, 0, 0, 0, 1,  0,1,0,0,1,0, 5});  // done 21 cycles after request
        vq.push_back('{1, 1, 0, 0, 1,  0,1,0,0,0,1, 5});  // both requests
        vq.push_back('{0, 1, 0, 0, 1,  0,1,0,0,0,1, 5});  // state already held
        vq.push_back('{1, 0, 0, 1, 1,  0,1,0,0,0,1, 5});  // outer port open
        vq.push_back('{0, 0, 0, 0, 1,  0,1,0,0,0,0, 5});
        vq.push_back('{1, 0, 0, 0, 1,  0,0,1,0,0,0, 0});  // interlock abort run
        vq.push_back('{0, 0, 0, 0, 12, 0,0,1,0,0,0, 3});
        vq.push_back('{0, 0, 1, 0, 1,  0,0,0,1,0,0, 3});  // inner port opens
        vq.push_back('{1, 0, 0, 0, 1,  0,0,0,1,0,1, 3});  // pressurize in fault ignored
        vq.push_back('{0, 1, 0, 0, 1,  0,0,1,0,0,0, 0});  // recovery evacuate
        vq.push_back('{0, 0, 0, 0, 20, 0,1,0,0,1,0, 5});
        vq.push_back('{1, 0, 0, 0, 1,  0,0,1,0,0,0, 0});  // busy collision run
        vq.push_back('{0, 0, 0, 0, 8,  0,0,1,0,0,0, 2});
        vq.push_back('{0, 1, 0, 0, 1,  0,0,1,0,0,1, 2});  // evacuate while busy
        vq.push_back('{0, 0, 0, 0, 18, 0,0,1,0,0,0, 6});
        vq.push_back('{0, 0, 0, 0, 1,  1,0,0,0,1,0, 7});
        vq.push_back('{1, 0, 0, 0, 1,  1,0,0,0,0,1, 7});  // pressurize on done cycle
        vq.push_back('{0, 0, 0, 0, 1,  1,0,0,0,0,0, 7});

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst.evacuated", 32'(evacuated), 32'd1);
        chk("rst.busy_flags", 32'({pressurized, busy, fault, done}), 32'd0);
        chk("rst.seconds", 32'(seconds), 32'd0);
        reset = 1'b0;

        foreach (vq[i]) begin
            for (int c = 0; c < vq[i].cyc; c++)
                cycle((c == 0) ? vq[i].pr : 1'b0, (c == 0) ? vq[i].ev : 1'b0, vq[i].ip, vq[i].op);
            chk($sformatf("vec%0d.pressurized", i), 32'(pressurized), 32'(vq[i].p));
            chk($sformatf("vec%0d.evacuated", i),   32'(evacuated),   32'(vq[i].e));
            chk($sformatf("vec%0d.busy", i),        32'(busy),        32'(vq[i].b));
            chk($sformatf("vec%0d.fault", i),       32'(fault),       32'(vq[i].f));
            chk($sformatf("vec%0d.done", i),        32'(done),        32'(vq[i].d));
            chk($sformatf("vec%0d.seconds", i),     32'(seconds),     32'(vq[i].sec));
`ifdef PRESSURE_REJECT_EN
            chk($sformatf("vec%0d.reject", i),      32'(reject),      32'(vq[i].r));
`endif
        end

        // Mid-cycle reset at seconds=4 of evacuate
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 16; c++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst.pre_seconds", 32'(seconds), 32'd4);
        chk("mrst.pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst.evacuated", 32'(evacuated), 32'd1);
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.seconds", 32'(seconds), 32'd0);
        chk("mrst.done", 32'(done), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            chk("mrst.no_done", 32'(done), 32'd0);
            chk("mrst.stay_evac", 32'(evacuated), 32'd1);
        end

        // Random stimulus against the model
        reset = 1'b1;
        #1;
        model_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check_model("rnd.reset");
        for (int n = 0; n < 3000; n++) begin
            bit pr, ev, ip, op;
            pr = ($urandom_range(0, 7) == 0);
            ev = ($urandom_range(0, 7) == 0);
            ip = ($urandom_range(0, 99) < 2);
            op = ($urandom_range(0, 99) < 2);
            cycle(pr, ev, ip, op);
            model_step(pr, ev, ip, op);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chamber_pressure_plant.md
Name: chamber_pressure_plant

Overview:
- Responder side of the airlock pressurize/evacuate command interface: accepts single-cycle pressurize/evacuate requests, runs the timed pump cycle, and reports chamber state back to the entering/leaving interlock FSMs.
- Owns the seconds count that the top level currently builds from a free-running timer, so the 5 s evacuate / 7 s pressurize durations live in one place.
- Enforces the port interlock: no pump activity while either port is open.

Parameters:
- TICKS_PER_SEC, 64, clock cycles per counted second (bench overrides to 4)
- PRESS_SEC, 7, seconds to pressurize; legal range 1..15
- EVAC_SEC, 5, seconds to evacuate; legal range 1..15

Ports:
- clock  in  1  system clock (the divided clk[whichClock] net)
- reset  in  1  asynchronous, active-high reset
- pressurizeReq  in  1  one-cycle request pulse, already synchronised
- evacuateReq  in  1  one-cycle request pulse, already synchronised
- innerPortOpen  in  1  level, synchronised
- outerPortOpen  in  1  level, synchronised
- pressurized  out  1  chamber at full pressure
- evacuated  out  1  chamber at vacuum
- busy  out  1  pump cycle in progress
- fault  out  1  cycle aborted, chamber state unknown
- done  out  1  one-cycle pulse when a cycle completes
- seconds  out  4  elapsed whole seconds of the current cycle

Behaviour:
- States: EVACUATED (reset), PRESSURIZING, PRESSURIZED, EVACUATING, FAULT. All state and outputs are registered.
- Reset values: state=EVACUATED, evacuated=1, all other outputs 0, seconds=0, tick counter=0.
- portsClosed = !innerPortOpen && !outerPortOpen.
- Accepted request: exactly one of the two request inputs is high in a cycle.
- EVACUATED:
  - Accepted pressurizeReq with portsClosed -> PRESSURIZING next cycle.
  - On entry: busy=1, evacuated=0, seconds=0, tick counter=0.
- PRESSURIZED:
  - Accepted evacuateReq with portsClosed -> EVACUATING, with the same entry actions.
- PRESSURIZING / EVACUATING:
  - Tick counter counts 0..TICKS_PER_SEC-1.
  - On wrap, seconds increments.
  - When seconds reaches PRESS_SEC (or EVAC_SEC), in that same update go to PRESSURIZED (or EVACUATED): busy=0, done=1 for exactly one cycle, and the status flag is set.
  - seconds holds its final value until the next cycle starts.
  - Latency, request to done: 1 + SEC*TICKS_PER_SEC cycles.
- Any port opening while busy -> FAULT next cycle: busy=0, fault=1, pressurized=0, evacuated=0, seconds frozen, no done pulse.
- FAULT: only exit is an accepted evacuateReq with portsClosed -> EVACUATING; fault clears on entry.
- Ignored requests (no state change):
  - pressurizeReq and evacuateReq high in the same cycle
  - any request while busy
  - a request for the state already held
  - any request while a port is open
  - pressurizeReq in FAULT
- Request in the same cycle a cycle completes: the request is ignored because busy=1 that cycle.
- reset asserted mid-cycle: immediate return to reset values, with no done pulse.
- Exactly one of pressurized, evacuated, busy, or fault is high at all times after reset.

Optional Feature:
- Macro: PRESSURE_REJECT_EN
- When defined: adds output port `reject` (1 bit). It pulses high for one cycle, registered, on every request pulse that is ignored under the rules above.
- When not defined: the port is absent and ignored requests are silently dropped.

Test Plan (TICKS_PER_SEC=4, PRESS_SEC=7, EVAC_SEC=5):
- Normal pressurize: reset, ports closed, pressurizeReq pulse -> busy=1 next cycle; seconds steps 1..7 every 4 cycles; done pulse and pressurized=1 exactly 29 cycles after the request; seconds=7 held.
- Normal evacuate: from PRESSURIZED, evacuateReq -> evacuated=1 and done after 21 cycles; seconds=5.
- Interlock abort: during pressurize at seconds=3, innerPortOpen=1 -> fault=1 next cycle, seconds=3, no done. pressurizeReq in FAULT is ignored. After the port closes, evacuateReq -> EVACUATING, then evacuated=1 after 21 cycles.
- Rejected requests: simultaneous pressurizeReq+evacuateReq in EVACUATED -> no change. evacuateReq in EVACUATED -> no change. pressurizeReq with outerPortOpen=1 -> no change. With PRESSURE_REJECT_EN defined, reject pulses once for each.
- Busy collision: evacuateReq at seconds=2 of pressurize, and pressurizeReq on the done cycle -> both ignored; pressurized=1 and stays.
- Reset mid-cycle: assert reset at seconds=4 of evacuate -> asynchronously evacuated=1, busy=0, seconds=0, done never pulses.
